uart_wb_loader: RTL and testbench
=================================

# uart_wb_loader

Wishbone bus master that turns a byte stream from the UART receiver into word writes on the data port of the Wishbone-wrapped dual-port RAM. It uses this stream to preload weights and input maps before the CNN cores start. It parses a length header, packs four bytes per word little-endian, and issues one single-beat Wishbone write per word to consecutive addresses. It then reports completion to the GPIO `led_done` path and to the core controller.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: Wishbone address width; addresses are word indices, matching the RAM port.
- `DATA_WIDTH`, 32: word width; only 32 is supported, giving 4 bytes per word.
- `BASE_ADDR`, 0: address of the first word written.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, asynchronous, active-low (asserted at 0).
- `arm`  in  1: 1-cycle pulse; clears status and starts a new load.
- `rx_stb`  in  1: 1-cycle strobe, a received byte is valid.
- `rx_data`  in  8: received byte.
- `wb_cyc_o`  out  1: Wishbone cycle.
- `wb_stb_o`  out  1: Wishbone strobe.
- `wb_we_o`  out  1: Wishbone write enable; always 1 while a write is in progress.
- `wb_adr_o`  out  ADDR_WIDTH: write address.
- `wb_dat_o`  out  DATA_WIDTH: write data.
- `wb_ack_i`  in  1: slave acknowledge.
- `busy`  out  1: a load is in progress.
- `done`  out  1: sticky, load complete; cleared by `arm`.
- `err_ovr`  out  1: sticky, a word was dropped because the write channel was busy.
- `err_cksum`  out  1: sticky, checksum mismatch (only when the checksum feature is compiled in; otherwise tied 0).
- `words_written`  out  16: count of acked writes in the current load.

## Operation
- Frame format: `CNT_LO`, `CNT_HI` (16-bit word count N, little-endian), then 4·N data bytes. Byte 0 of each group is `wb_dat_o[7:0]`.
- States:
  - `IDLE`: waits for `arm`, then goes to `HDR0`.
  - `HDR0`: on `rx_stb`, captures `CNT_LO` and goes to `HDR1`.
  - `HDR1`: on `rx_stb`, captures `CNT_HI`. Goes to `DATA`, or to the post-payload state if N = 0.
  - `DATA`: on the 4th byte of word i, the packed word goes to the write channel at address `BASE_ADDR + i`. After word N−1 is handed off, goes to `DRAIN`.
  - `DRAIN`: waits until the write channel is idle, then goes to `DONE` (or `CKSUM` when compiled in).
  - `DONE`: holds `done`=1. `arm` restarts at `HDR0`.
- Write channel: one pending-word register, independent of the byte packer so packing continues during a write.
  - If a word completes while a write is still pending, the new word is dropped and `err_ovr` is set.
  - The word index still advances on a drop, so later words keep their addresses.
- `rx_stb` in `IDLE` or `DONE` is ignored.
- `arm` in any state aborts the current load, including any pending write (`cyc`/`stb` drop next edge). It clears `done`, both error flags, `words_written` and the packer, and enters `HDR0`.
- Address arithmetic: `BASE_ADDR + i` wraps modulo 2^ADDR_WIDTH. `words_written` saturates at 0xFFFF.

## Timing
- Reset: every output is 0 and the state is `IDLE`; this takes effect immediately on `rst` falling. The same holds when reset arrives mid-load: the bus is released at once with no completion.
- `busy` = 1 in `HDR0` through `DRAIN`/`CKSUM`.
- Write start: `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_adr_o` and `wb_dat_o` are registered. They go high the edge after the `rx_stb` that completes a word.
- Write hold: all write signals are held stable until `wb_ack_i`=1 is sampled. They drop on that same edge, when `words_written` also increments.
- Latency: with the RAM wrapper (registered ack) a write occupies 2 cycles of `stb`. A repeat write of the identical word on the second cycle is acceptable.
- `wb_ack_i` sampled while no write is pending is ignored.
- There is no timeout; a stalled slave holds `busy` until `arm` or reset.

## Configuration
- `LOADER_CKSUM_EN` defined:
  - One extra byte follows the payload: the XOR of all 4·N data bytes, header excluded.
  - After `DRAIN`, the state is `CKSUM`, which waits for that byte.
  - A mismatch sets `err_cksum`. `DONE` is entered either way.
- `LOADER_CKSUM_EN` undefined: `DRAIN` goes directly to `DONE`, no XOR logic exists, and `err_cksum` = 0.

## Structure
- Package `loader_pkg` holds:
  - the state enum;
  - `HDR_BYTES` = 2;
  - `BYTES_PER_WORD` = 4.
- Sub-module `byte_packer` holds the 2-bit byte counter and shift register. It outputs `word_valid` (1 cycle) and `word`, and clears on `arm`.
- The FSM, word index and write channel live in `uart_wb_loader`.

## Test plan
- **N=2 happy path:** `arm`, bytes 02 00 11 22 33 44 AA BB CC DD with a slave acking 1 cycle after `stb`, `BASE_ADDR`=0x10 → writes 0x44332211 at 0x10 and 0xDDCCBBAA at 0x11. Then `words_written`=2, `done`=1, `busy`=0.
- **N=0:** `arm`, bytes 00 00 → `done`=1 two strobes after `arm`, no `wb_cyc_o` activity.
- **Overrun:** slave withholds ack for 10 cycles while 4 more bytes arrive back-to-back → `err_ovr`=1, second word never written, third word lands at `BASE_ADDR`+2.
- **Abort:** `arm` mid-write with `stb` high → `cyc`/`stb` 0 next cycle, `words_written`=0, parser back in `HDR0`.
- **Async reset mid-`DATA`:** drive `rst`=0 → all outputs 0 before the next clock edge. Release, then a new `arm` plus full frame loads correctly.
- **Checksum (`LOADER_CKSUM_EN`):** frame 01 00 01 02 03 04 then 04 → `err_cksum`=0. Same frame with trailer 05 → `err_cksum`=1, `done`=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared state encoding and framing constants for the UART-to-Wishbone loader.
// Optional trailer checksum is enabled with the LOADER_CKSUM_EN macro.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_DRAIN,
        S_CKSUM,
        S_DONE
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Collects received bytes into little-endian 32-bit words; the completed word
// is presented combinationally alongside the strobe that supplies its last byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    assign word_valid = en_i && !clear_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word       = {byte_i, shift_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (en_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_i, shift_q[23:8]};
        end
    end

endmodule

// File: rtl/uart_wb_loader.sv
// Parses a length-prefixed UART byte stream and writes it word by word over Wishbone.
// Define LOADER_CKSUM_EN to require and verify an XOR trailer byte after the payload.
module uart_wb_loader
    import loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  rx_stb,
    input  logic [7:0]            rx_data,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic                  wb_ack_i,
    output logic                  busy,
    output logic                  done,
    output logic                  err_ovr,
    output logic                  err_cksum,
    output logic [15:0]           words_written
);

    state_e                  state_q;
    logic                    busy_q, done_q, ovr_q, cyc_q;
    logic [15:0]             cnt_q, idx_q, written_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;

    logic                    packEn, wordValid;
    logic [31:0]             packedWord;
    logic [15:0]             written_d;
    logic [ADDR_WIDTH-1:0]   adr_d;
    logic                    lastWord_d;

    assign packEn     = rx_stb && (state_q == S_DATA);
    assign written_d  = (written_q == 16'hFFFF) ? written_q : written_q + 16'd1;
    assign adr_d      = BASE_ADDR + ADDR_WIDTH'(idx_q);
    assign lastWord_d = (idx_q == cnt_q - 16'd1);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (arm),
        .en_i       (packEn),
        .byte_i     (rx_data),
        .word_valid (wordValid),
        .word       (packedWord)
    );

    // The write channel runs beside the FSM so packing continues during a write;
    // a word finishing while a write is still pending is dropped but keeps its index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            cyc_q     <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            written_q <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
        end else if (arm) begin
            state_q   <= S_HDR0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            cyc_q     <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            written_q <= '0;
        end else begin
            if (cyc_q && wb_ack_i) begin
                cyc_q     <= 1'b0;
                written_q <= written_d;
            end
            if (wordValid) begin
                if (cyc_q) begin
                    ovr_q <= 1'b1;
                end else begin
                    cyc_q <= 1'b1;
                    adr_q <= adr_d;
                    dat_q <= DATA_WIDTH'(packedWord);
                end
                idx_q <= idx_q + 16'd1;
            end

            case (state_q)
                S_HDR0: begin
                    if (rx_stb) begin
                        cnt_q[7:0] <= rx_data;
                        state_q    <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (rx_stb) begin
                        cnt_q[15:8] <= rx_data;
                        state_q     <= ({rx_data, cnt_q[7:0]} == 16'd0) ? S_DRAIN : S_DATA;
                    end
                end
                S_DATA: begin
                    if (wordValid && lastWord_d) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!cyc_q) begin
`ifdef LOADER_CKSUM_EN
                        state_q <= S_CKSUM;
`else
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end
                end
`ifdef LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (rx_stb) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef LOADER_CKSUM_EN
    logic [7:0] xor_q;
    logic       cksumErr_q;

    // Running XOR covers payload bytes only; the trailer is compared once in S_CKSUM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xor_q      <= '0;
            cksumErr_q <= 1'b0;
        end else if (arm) begin
            xor_q      <= '0;
            cksumErr_q <= 1'b0;
        end else if (rx_stb && state_q == S_DATA) begin
            xor_q <= xor_q ^ rx_data;
        end else if (rx_stb && state_q == S_CKSUM) begin
            cksumErr_q <= (rx_data != xor_q);
        end
    end

    assign err_cksum = cksumErr_q;
`else
    assign err_cksum = 1'b0;
`endif

    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = cyc_q;
    assign wb_we_o       = cyc_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_ovr       = ovr_q;
    assign words_written = written_q;

endmodule

// File: tb/tb_uart_wb_loader.sv
// Self-checking bench for uart_wb_loader: a frame-level reference model predicts
// every Wishbone write and the final status; build with LOADER_CKSUM_EN to cover the trailer.
`timescale 1ns/1ps
module tb_uart_wb_loader;

    localparam logic [31:0] BASE = 32'h10;
`ifdef LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arm = 1'b0;
    logic        rx_stb = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic        busy, done, err_ovr, err_cksum;
    logic [15:0] words_written;

    int vectors = 0;
    int miscompares = 0;
    int cycleCount = 0;
    int ackDelay = 1;
    bit spurEn = 1'b0;

    // Frame-level reference model state
    int          mPhase, mN, mBytes, mWordIdx, mFreeAt, mLastCycle, mWritten;
    logic [31:0] mWord;
    logic [7:0]  mXor;
    bit          mOvr, mCkErr;
    logic [31:0] expAdr[$], expDat[$], logAdr[$], logDat[$];
    logic [7:0]  payload[$];

    int          waitCnt = 0;
    bit          holdPrev = 1'b0;
    logic [31:0] prevAdr, prevDat;

    uart_wb_loader #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .rx_stb        (rx_stb),
        .rx_data       (rx_data),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_i      (wb_ack_i),
        .busy          (busy),
        .done          (done),
        .err_ovr       (err_ovr),
        .err_cksum     (err_cksum),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic modelClear(input int phase);
        mPhase = phase; mN = 0; mBytes = 0; mWordIdx = 0; mFreeAt = 0;
        mLastCycle = 0; mWritten = 0; mWord = '0; mXor = '0; mOvr = 0; mCkErr = 0;
        expAdr.delete(); expDat.delete(); logAdr.delete(); logDat.delete();
    endtask

    // A completed word is written only if the previous write (ack after ackDelay
    // extra cycles) has finished by the cycle the word completes.
    task automatic modelByte(input logic [7:0] b, input int c);
        case (mPhase)
            1: begin mN = int'(b); mPhase = 2; end
            2: begin
                mN = mN + 256 * int'(b);
                mLastCycle = c;
                mPhase = (mN == 0) ? (CK ? 4 : 5) : 3;
            end
            3: begin
                mXor ^= b;
                mWord = {b, mWord[31:8]};
                mBytes++;
                mLastCycle = c;
                if (mBytes % 4 == 0) begin
                    if (c >= mFreeAt) begin
                        expAdr.push_back(BASE + 32'(mWordIdx));
                        expDat.push_back(mWord);
                        mFreeAt = c + 2 + ackDelay;
                        mWritten++;
                    end else begin
                        mOvr = 1;
                    end
                    mWordIdx++;
                    if (mWordIdx == mN) mPhase = CK ? 4 : 5;
                end
            end
            4: begin mCkErr = (b != mXor); mPhase = 5; end
            default: ;
        endcase
    endtask

    // Wishbone slave plus the per-cycle compare process
    always @(negedge clk) begin
        if (!rst) begin
            wb_ack_i = 1'b0;
            waitCnt  = 0;
            holdPrev = 1'b0;
        end else begin
            checkOutput("busyAndDone", 32'(busy & done), 32'd0);
            if (wb_cyc_o) begin
                checkOutput("stbWithCyc", 32'(wb_stb_o), 32'd1);
                checkOutput("weWithCyc", 32'(wb_we_o), 32'd1);
                if (holdPrev) begin
                    checkOutput("holdAdr", wb_adr_o, prevAdr);
                    checkOutput("holdDat", wb_dat_o, prevDat);
                end
                if (waitCnt >= ackDelay) begin
                    wb_ack_i = 1'b1;
                    waitCnt  = 0;
                    holdPrev = 1'b0;
                    logAdr.push_back(wb_adr_o);
                    logDat.push_back(wb_dat_o);
                    if (expAdr.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpectedWrite: got adr %0h dat %0h, required no write", wb_adr_o, wb_dat_o);
                    end else begin
                        checkOutput("writeAdr", wb_adr_o, expAdr.pop_front());
                        checkOutput("writeDat", wb_dat_o, expDat.pop_front());
                    end
                end else begin
                    wb_ack_i = 1'b0;
                    waitCnt++;
                    holdPrev = 1'b1;
                    prevAdr  = wb_adr_o;
                    prevDat  = wb_dat_o;
                end
            end else begin
                holdPrev = 1'b0;
                waitCnt  = 0;
                wb_ack_i = spurEn && ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic pulseArm();
        arm = 1'b1;
        modelClear(1);
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        rx_stb  = 1'b1;
        rx_data = b;
        modelByte(b, cycleCount);
        @(posedge clk); #1;
        rx_stb = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic sendTrailer(input bit corrupt);
        int target;
        target = ((mFreeAt > mLastCycle + 1) ? mFreeAt : mLastCycle + 1) + 2;
        while (cycleCount < target) begin @(posedge clk); #1; end
        sendByte(mXor ^ (corrupt ? 8'h01 : 8'h00), 0);
    endtask

    task automatic applyStimulus(input bit doArm, input int gapMax, input bit corrupt);
        logic [15:0] n16;
        n16 = 16'(payload.size() / 4);
        if (doArm) pulseArm();
        sendByte(n16[7:0], int'($urandom_range(0, gapMax)));
        sendByte(n16[15:8], int'($urandom_range(0, gapMax)));
        foreach (payload[i]) sendByte(payload[i], int'($urandom_range(0, gapMax)));
        if (CK) sendTrailer(corrupt);
    endtask

    task automatic checkFrame(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        checkOutput({tag, ".done"}, 32'(done), 32'd1);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".wordsWritten"}, 32'(words_written), 32'(mWritten));
        checkOutput({tag, ".errOvr"}, 32'(err_ovr), 32'(mOvr));
        checkOutput({tag, ".errCksum"}, 32'(err_cksum), 32'(mCkErr));
        checkOutput({tag, ".pendingWrites"}, 32'(expAdr.size()), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".cyc"}, 32'(wb_cyc_o), 32'd0);
        checkOutput({tag, ".stb"}, 32'(wb_stb_o), 32'd0);
        checkOutput({tag, ".we"}, 32'(wb_we_o), 32'd0);
        checkOutput({tag, ".adr"}, wb_adr_o, 32'd0);
        checkOutput({tag, ".dat"}, wb_dat_o, 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".errOvr"}, 32'(err_ovr), 32'd0);
        checkOutput({tag, ".errCksum"}, 32'(err_cksum), 32'd0);
        checkOutput({tag, ".wordsWritten"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelClear(0);
        #2;
        checkAllZero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // N=2 happy path, slave acks one cycle after stb
        ackDelay = 1;
        payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        applyStimulus(1'b1, 0, 1'b0);
        checkFrame("happy");
        checkOutput("happy.nWrites", 32'(logAdr.size()), 32'd2);
        checkOutput("happy.adr0", logAdr[0], 32'h10);
        checkOutput("happy.dat0", logDat[0], 32'h44332211);
        checkOutput("happy.adr1", logAdr[1], 32'h11);
        checkOutput("happy.dat1", logDat[1], 32'hDDCCBBAA);
        checkOutput("happy.literalWritten", 32'(words_written), 32'd2);

        // N=0: completion without any bus activity
        payload.delete();
        applyStimulus(1'b1, 0, 1'b0);
        checkFrame("zero");
        checkOutput("zero.nWrites", 32'(logAdr.size()), 32'd0);

        // Overrun: long ack stall, second word dropped, third keeps its address
        ackDelay = 10;
        pulseArm();
        sendByte(8'h03, 0); sendByte(8'h00, 0);
        sendByte(8'h01, 0); sendByte(8'h02, 0); sendByte(8'h03, 0); sendByte(8'h04, 0);
        sendByte(8'h05, 0); sendByte(8'h06, 0); sendByte(8'h07, 0); sendByte(8'h08, 12);
        sendByte(8'h09, 0); sendByte(8'h0A, 0); sendByte(8'h0B, 0); sendByte(8'h0C, 0);
        if (CK) sendTrailer(1'b0);
        checkFrame("overrun");
        checkOutput("overrun.literalOvr", 32'(err_ovr), 32'd1);
        checkOutput("overrun.nWrites", 32'(logAdr.size()), 32'd2);
        checkOutput("overrun.adr1", logAdr[1], 32'h12);
        checkOutput("overrun.dat1", logDat[1], 32'h0C0B0A09);

        // Abort with stb high, then a frame without re-arming proves the parser is in HDR0
        ackDelay = 10;
        pulseArm();
        sendByte(8'h01, 0); sendByte(8'h00, 0);
        sendByte(8'h5A, 0); sendByte(8'h6B, 0); sendByte(8'h7C, 0); sendByte(8'h8D, 0);
        checkOutput("abort.stbBefore", 32'(wb_stb_o), 32'd1);
        pulseArm();
        checkOutput("abort.cyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("abort.stb", 32'(wb_stb_o), 32'd0);
        checkOutput("abort.wordsWritten", 32'(words_written), 32'd0);
        checkOutput("abort.busy", 32'(busy), 32'd1);
        ackDelay = 1;
        payload = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        applyStimulus(1'b0, 1, 1'b0);
        checkFrame("afterAbort");
        checkOutput("afterAbort.dat0", logDat[0], 32'hDEADBEEF);

        // Asynchronous reset in the middle of the payload
        ackDelay = 2;
        pulseArm();
        sendByte(8'h02, 0); sendByte(8'h00, 0);
        sendByte(8'h11, 0); sendByte(8'h22, 0); sendByte(8'h33, 0); sendByte(8'h44, 0);
        sendByte(8'hAA, 0);
        #2;
        rst = 1'b0;
        modelClear(0);
        #1;
        checkAllZero("midReset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("postReset.busy", 32'(busy), 32'd0);
        ackDelay = 1;
        payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        applyStimulus(1'b1, 1, 1'b0);
        checkFrame("postReset");
        checkOutput("postReset.dat0", logDat[0], 32'h44332211);
        checkOutput("postReset.dat1", logDat[1], 32'hDDCCBBAA);

`ifdef LOADER_CKSUM_EN
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(1'b1, 0, 1'b0);
        checkFrame("cksumGood");
        checkOutput("cksumGood.literal", 32'(err_cksum), 32'd0);
        applyStimulus(1'b1, 0, 1'b1);
        checkFrame("cksumBad");
        checkOutput("cksumBad.literal", 32'(err_cksum), 32'd1);
        checkOutput("cksumBad.done", 32'(done), 32'd1);
`endif

        // Randomized frames with varying ack latency, byte gaps and spurious acks
        for (int f = 0; f < 12; f++) begin
            int n;
            ackDelay = int'($urandom_range(0, 3));
            spurEn   = 1'($urandom_range(0, 1));
            n        = int'($urandom_range(0, 6));
            payload.delete();
            for (int k = 0; k < 4 * n; k++) payload.push_back(8'($urandom_range(0, 255)));
            applyStimulus(1'b1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            checkFrame("random");
        end
        spurEn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
